// File: rtl/axi_read_arbiter_if.sv
// AXI read address and read data channels between the arbiter (master) and a slave.
interface axi_read_arbiter_if #(
   parameter int unsigned BusWidth = 32,
   parameter int unsigned tagbits  = 1
);
   logic [tagbits-1:0]  ARID;
   logic [BusWidth-1:0] ARADDR;
   logic [3:0]          ARLEN;
   logic [1:0]          ARSIZE;
   logic [1:0]          ARBURST;
   logic                ARVALID;
   logic                ARREADY;
   logic [tagbits-1:0]  RID;
   logic [BusWidth-1:0] RDATA;
   logic [1:0]          RRESP;
   logic                RLAST;
   logic                RVALID;
   logic                RREADY;

   modport master (
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
      input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
   );

   modport slave (
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
      output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
   );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-requester round-robin AXI read arbiter with per-requester outstanding-burst limits
// and ID-based routing of read responses.
module axi_read_arbiter #(
   parameter int unsigned BusWidth = 32,
   parameter int unsigned tagbits  = 1,
   parameter int unsigned MaxOutst = 2
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [BusWidth-1:0] req0_addr,
   input  logic [3:0]          req0_len,
   input  logic [1:0]          req0_size,
   input  logic [1:0]          req0_burst,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [BusWidth-1:0] req1_addr,
   input  logic [3:0]          req1_len,
   input  logic [1:0]          req1_size,
   input  logic [1:0]          req1_burst,
   output logic [BusWidth-1:0] rsp_data,
   output logic [1:0]          rsp_resp,
   output logic                rsp_last,
   output logic                rsp0_valid,
   input  logic                rsp0_ready,
   output logic                rsp1_valid,
   input  logic                rsp1_ready,
   output logic [1:0]          outst0,
   output logic [1:0]          outst1,
   axi_read_arbiter_if.master  axi
);

   localparam logic [1:0] MaxCnt = 2'(MaxOutst);

   typedef enum logic [0:0] {StIdle, StIssue} state_e;

   state_e              state_q;
   logic                last_grant_q;
   logic [tagbits-1:0]  ar_id_q;
   logic [BusWidth-1:0] ar_addr_q;
   logic [3:0]          ar_len_q;
   logic [1:0]          ar_size_q;
   logic [1:0]          ar_burst_q;
   logic [1:0]          outst0_q, outst1_q;

   logic elig0, elig1, gnt_any, gnt_sel;
   logic ar_hs, r_done, rid_ok, rid_one;
   logic inc0, inc1, dec0, dec1;

   // Arbitration
   assign elig0   = (state_q == StIdle) && req0_valid && (outst0_q < MaxCnt);
   assign elig1   = (state_q == StIdle) && req1_valid && (outst1_q < MaxCnt);
   assign gnt_any = elig0 || elig1;
   assign gnt_sel = (elig0 && elig1) ? ~last_grant_q : elig1;

   assign req0_ready = gnt_any && !gnt_sel;
   assign req1_ready = gnt_any && gnt_sel;

   assign axi.ARVALID = (state_q == StIssue);
   assign axi.ARID    = ar_id_q;
   assign axi.ARADDR  = ar_addr_q;
   assign axi.ARLEN   = ar_len_q;
   assign axi.ARSIZE  = ar_size_q;
   assign axi.ARBURST = ar_burst_q;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         ar_id_q      <= '0;
         ar_addr_q    <= '0;
         ar_len_q     <= '0;
         ar_size_q    <= '0;
         ar_burst_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (gnt_any) begin
                  state_q      <= StIssue;
                  last_grant_q <= gnt_sel;
                  ar_id_q      <= tagbits'(gnt_sel);
                  ar_addr_q    <= gnt_sel ? req1_addr  : req0_addr;
                  ar_len_q     <= gnt_sel ? req1_len   : req0_len;
                  ar_size_q    <= gnt_sel ? req1_size  : req0_size;
                  ar_burst_q   <= gnt_sel ? req1_burst : req0_burst;
               end
            end
            StIssue: begin
               if (axi.ARREADY) state_q <= StIdle;
            end
         endcase
      end
   end

   // Response routing; IDs beyond the two requesters are drained and ignored.
   assign rid_ok  = (axi.RID >> 1) == '0;
   assign rid_one = axi.RID[0];

   assign rsp0_valid = axi.RVALID && rid_ok && !rid_one;
   assign rsp1_valid = axi.RVALID && rid_ok && rid_one;
   assign axi.RREADY = !rid_ok ? 1'b1 : (rid_one ? rsp1_ready : rsp0_ready);

   assign rsp_data = axi.RDATA;
   assign rsp_resp = axi.RRESP;
   assign rsp_last = axi.RLAST;

   // Outstanding-burst accounting
   assign ar_hs  = axi.ARVALID && axi.ARREADY;
   assign r_done = axi.RVALID && axi.RREADY && axi.RLAST && rid_ok;
   assign inc0   = ar_hs && !ar_id_q[0];
   assign inc1   = ar_hs && ar_id_q[0];
   assign dec0   = r_done && !rid_one;
   assign dec1   = r_done && rid_one;

   function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic inc,
                                           input logic dec);
      if (inc && !dec) return cnt + 2'd1;
      if (dec && !inc && (cnt != 2'd0)) return cnt - 2'd1;
      return cnt;
   endfunction

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         outst0_q <= 2'd0;
         outst1_q <= 2'd0;
      end else begin
         outst0_q <= cnt_next(outst0_q, inc0, dec0);
         outst1_q <= cnt_next(outst1_q, inc1, dec1);
      end
   end

   assign outst0 = outst0_q;
   assign outst1 = outst1_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: directed scenarios plus random traffic checked
// every cycle against a transaction-level model of grants and outstanding bursts.
module tb_axi_read_arbiter;
   localparam int unsigned BusWidth = 32;
   localparam int unsigned Tagbits  = 1;
   localparam int unsigned MaxOutst = 2;

   logic                ACLK = 1'b0;
   logic                ARESETn;
   logic                req0_valid, req1_valid, req0_ready, req1_ready;
   logic [BusWidth-1:0] req0_addr, req1_addr;
   logic [3:0]          req0_len, req1_len;
   logic [1:0]          req0_size, req1_size, req0_burst, req1_burst;
   logic [BusWidth-1:0] rsp_data;
   logic [1:0]          rsp_resp;
   logic                rsp_last, rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [1:0]          outst0, outst1;

   axi_read_arbiter_if #(.BusWidth(BusWidth), .tagbits(Tagbits)) axi ();

   axi_read_arbiter #(.BusWidth(BusWidth), .tagbits(Tagbits), .MaxOutst(MaxOutst)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
      .req0_len(req0_len), .req0_size(req0_size), .req0_burst(req0_burst),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
      .req1_len(req1_len), .req1_size(req1_size), .req1_burst(req1_burst),
      .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_last(rsp_last),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .outst0(outst0), .outst1(outst1), .axi(axi.master)
   );

   always #5 ACLK = ~ACLK;

   int n_checks = 0;
   int n_err    = 0;

   // Model: outstanding counts, the one AR request waiting on the bus, and who won last.
   int          m_out[2];
   bit          m_pend;
   int          m_id, m_last;
   logic [31:0] m_addr;
   logic [3:0]  m_len;
   logic [1:0]  m_size, m_burst;
   int          ar_log[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_out[0] = 0;
      m_out[1] = 0;
      m_pend   = 1'b0;
      m_last   = 1;
   endfunction

   // Called at a falling edge with inputs applied; checks, advances the model, waits a cycle.
   task automatic tick();
      bit e0, e1, any, exp_rr;
      int g;
      int d[2];
      #1;
      if (!ARESETn) model_reset();
      e0  = !m_pend && req0_valid && (m_out[0] < MaxOutst);
      e1  = !m_pend && req1_valid && (m_out[1] < MaxOutst);
      any = e0 || e1;
      g   = (e0 && e1) ? 1 - m_last : (e1 ? 1 : 0);
      exp_rr = axi.RID[0] ? rsp1_ready : rsp0_ready;
      check("arvalid", axi.ARVALID, m_pend);
      if (m_pend) begin
         check("arid", axi.ARID, m_id);
         check("araddr", axi.ARADDR, m_addr);
         check("arlen", axi.ARLEN, m_len);
         check("arsize", axi.ARSIZE, m_size);
         check("arburst", axi.ARBURST, m_burst);
      end
      check("req0_ready", req0_ready, any && g == 0);
      check("req1_ready", req1_ready, any && g == 1);
      check("rready", axi.RREADY, exp_rr);
      check("rsp0_valid", rsp0_valid, axi.RVALID && !axi.RID[0]);
      check("rsp1_valid", rsp1_valid, axi.RVALID && axi.RID[0]);
      check("rsp_data", rsp_data, axi.RDATA);
      check("rsp_resp", rsp_resp, axi.RRESP);
      check("rsp_last", rsp_last, axi.RLAST);
      check("outst0", outst0, m_out[0]);
      check("outst1", outst1, m_out[1]);
      if (axi.ARVALID && axi.ARREADY) ar_log.push_back(int'(axi.ARID));
      if (ARESETn) begin
         d[0] = 0;
         d[1] = 0;
         if (m_pend && axi.ARREADY) begin
            d[m_id]++;
            m_pend = 1'b0;
         end else if (any) begin
            m_pend  = 1'b1;
            m_id    = g;
            m_last  = g;
            m_addr  = g ? req1_addr  : req0_addr;
            m_len   = g ? req1_len   : req0_len;
            m_size  = g ? req1_size  : req0_size;
            m_burst = g ? req1_burst : req0_burst;
         end
         if (axi.RVALID && exp_rr && axi.RLAST) d[axi.RID[0]]--;
         for (int i = 0; i < 2; i++) begin
            m_out[i] = m_out[i] + d[i];
            if (m_out[i] < 0) m_out[i] = 0;
         end
      end
      @(negedge ACLK);
   endtask

   task automatic r_beat(input logic id, input logic last);
      axi.RVALID = 1'b1;
      axi.RID    = id;
      axi.RLAST  = last;
      axi.RDATA  = $urandom;
      axi.RRESP  = 2'($urandom_range(0, 3));
   endtask

   initial begin
      ARESETn = 1'b0;
      {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = '0;
      req0_addr = '0; req1_addr = '0; req0_len = '0; req1_len = '0;
      req0_size = '0; req1_size = '0; req0_burst = '0; req1_burst = '0;
      axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RID = '0; axi.RDATA = '0;
      axi.RRESP = '0; axi.RLAST = 1'b0;
      model_reset();
      @(negedge ACLK);
      repeat (3) tick();

      // Both requesters from reset: grants alternate 0,1,0,1
      ARESETn = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_addr = 32'hA000_0000; req1_addr = 32'hB000_0000;
      req0_len = 4'd1; req1_len = 4'd7; req0_size = 2'd2; req1_size = 2'd1;
      req0_burst = 2'd1; req1_burst = 2'd2;
      axi.ARREADY = 1'b1;
      ar_log.delete();
      repeat (8) tick();
      check("alt_count", ar_log.size(), 4);
      for (int i = 0; i < 4 && i < ar_log.size(); i++) check("alt_id", ar_log[i], i % 2);
      req0_valid = 1'b0; req1_valid = 1'b0; axi.ARREADY = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         r_beat(i[0], 1'b1);
         tick();
      end
      axi.RVALID = 1'b0;
      #1;
      check("drain_outst0", outst0, 0);
      check("drain_outst1", outst1, 0);

      // AR payload held while ARREADY is low
      req0_valid = 1'b1; req0_addr = 32'h100; req0_len = 4'd3;
      tick();
      req0_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("hold_arvalid", axi.ARVALID, 1);
         check("hold_araddr", axi.ARADDR, 32'h100);
         tick();
      end
      axi.ARREADY = 1'b1;
      tick();
      axi.ARREADY = 1'b0;
      #1;
      check("hold_arvalid_drop", axi.ARVALID, 0);
      check("hold_outst0", outst0, 1);
      r_beat(1'b0, 1'b1);
      tick();
      axi.RVALID = 1'b0;

      // Requester 0 alone hits its outstanding limit
      req0_valid = 1'b1; axi.ARREADY = 1'b1;
      repeat (4) tick();
      #1;
      check("limit_ready", req0_ready, 0);
      check("limit_outst0", outst0, 2);
      repeat (2) tick();
      r_beat(1'b0, 1'b1);
      tick();
      axi.RVALID = 1'b0;
      #1;
      check("limit_after_r_outst0", outst0, 1);
      check("limit_after_r_ready", req0_ready, 1);
      repeat (2) tick();
      req0_valid = 1'b0; axi.ARREADY = 1'b0;
      for (int i = 0; i < 2; i++) begin
         r_beat(1'b0, 1'b1);
         tick();
      end
      axi.RVALID = 1'b0;

      // Response for requester 1 back-pressured, then completed
      req1_valid = 1'b1; axi.ARREADY = 1'b1;
      repeat (2) tick();
      req1_valid = 1'b0; axi.ARREADY = 1'b0;
      rsp1_ready = 1'b0;
      r_beat(1'b1, 1'b1);
      #1;
      check("bp_rready", axi.RREADY, 0);
      check("bp_rsp1_valid", rsp1_valid, 1);
      check("bp_rsp0_valid", rsp0_valid, 0);
      tick();
      rsp1_ready = 1'b1;
      tick();
      axi.RVALID = 1'b0;
      #1;
      check("bp_outst1", outst1, 0);

      // Increment and decrement of the same counter on one edge
      req0_valid = 1'b1;
      tick();
      axi.ARREADY = 1'b1;
      tick();
      axi.ARREADY = 1'b0;
      tick();
      req0_valid = 1'b0; axi.ARREADY = 1'b1;
      r_beat(1'b0, 1'b1);
      tick();
      axi.RVALID = 1'b0; axi.ARREADY = 1'b0;
      #1;
      check("same_edge_outst0", outst0, 1);
      r_beat(1'b0, 1'b1);
      tick();
      axi.RVALID = 1'b0;

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         req0_valid = ($urandom_range(0, 99) < 60);
         req1_valid = ($urandom_range(0, 99) < 60);
         req0_addr = $urandom; req1_addr = $urandom;
         req0_len = 4'($urandom); req1_len = 4'($urandom);
         req0_size = 2'($urandom); req1_size = 2'($urandom);
         req0_burst = 2'($urandom); req1_burst = 2'($urandom);
         axi.ARREADY = ($urandom_range(0, 99) < 60);
         rsp0_ready = ($urandom_range(0, 99) < 70);
         rsp1_ready = ($urandom_range(0, 99) < 70);
         if ($urandom_range(0, 99) < 50) r_beat(1'($urandom), 1'($urandom));
         else axi.RVALID = 1'b0;
         tick();
      end

      // Reset pulsed while a request is on the AR channel
      req0_valid = 1'b0; req1_valid = 1'b0; axi.RVALID = 1'b0; axi.ARREADY = 1'b1;
      tick();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         r_beat(i[0], 1'b1);
         tick();
      end
      axi.RVALID = 1'b0;
      req1_valid = 1'b1;
      repeat (2) tick();
      req1_valid = 1'b0; req0_valid = 1'b1; axi.ARREADY = 1'b0;
      tick();
      #1;
      check("pre_rst_arvalid", axi.ARVALID, 1);
      check("pre_rst_outst1", outst1, 1);
      ARESETn = 1'b0;
      #1;
      check("rst_arvalid", axi.ARVALID, 0);
      check("rst_outst0", outst0, 0);
      check("rst_outst1", outst1, 0);
      tick();
      ARESETn = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("post_rst_req0_ready", req0_ready, 1);
      check("post_rst_req1_ready", req1_ready, 0);
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter BusWidth, default 32, data and address width.
REQ-002 Parameter tagbits, default 1, ID width; ID value equals requester index (0 or 1).
REQ-003 Parameter MaxOutst, default 2, maximum outstanding bursts per requester (1..3).
REQ-004 ACLK  in  1  single clock; all state updates on the rising edge.
REQ-005 ARESETn  in  1  asynchronous, active-low reset.
REQ-006 reqN_valid / reqN_ready  in / out  1 each (N=0,1)  requester N read-request handshake.
REQ-007 reqN_addr / reqN_len / reqN_size / reqN_burst  in  BusWidth/4/2/2  requester N burst descriptor.
REQ-008 ARID / ARADDR / ARLEN / ARSIZE / ARBURST  out  tagbits/BusWidth/4/2/2  registered AR channel payload.
REQ-009 ARVALID  out  1  registered; ARREADY  in  1.
REQ-010 RID / RDATA / RRESP / RLAST / RVALID  in  tagbits/BusWidth/2/1/1  R channel from slave.
REQ-011 RREADY  out  1  combinational.
REQ-012 rsp_data / rsp_resp / rsp_last  out  BusWidth/2/1  R payload, passed through to both requesters.
REQ-013 rspN_valid  out  1; rspN_ready  in  1  per-requester response handshake.
REQ-014 outstN  out  2  outstanding-burst count for requester N.

Function
REQ-015 FSM has two states: IDLE (ARVALID=0) and ISSUE (ARVALID=1).
REQ-016 Requester N is eligible in IDLE when reqN_valid=1 and outstN<MaxOutst.
REQ-017 Arbitration is round-robin: with both eligible, grant the requester not granted last; with one eligible, grant it.
REQ-018 In IDLE, reqN_ready=1 combinationally for the granted requester only; both readies are 0 in ISSUE.
REQ-019 On a grant edge: load AR payload from reqN, set ARID=N, record last_grant=N, go to ISSUE.
REQ-020 In ISSUE the AR payload and ARVALID are held stable until ARREADY=1.
REQ-021 On the ARVALID&&ARREADY edge: go to IDLE (ARVALID=0 next cycle) and increment outst[ARID].
REQ-022 Minimum issue spacing is 2 cycles per burst (grant cycle, then handshake cycle).
REQ-023 R routing: rspN_valid = RVALID && (RID==N); RREADY = rsp[RID]_ready; both rspN_valid are 0 when RVALID=0.
REQ-024 rsp_data/rsp_resp/rsp_last equal RDATA/RRESP/RLAST combinationally.
REQ-025 On an RVALID&&RREADY&&RLAST edge, decrement outst[RID]; non-last beats leave counters unchanged.
REQ-026 If increment and decrement hit the same counter on one edge, the count is unchanged.
REQ-027 A counter never wraps; an RLAST handshake for an ID with count 0 leaves the count at 0.
REQ-028 At outstN==MaxOutst, requester N is not granted; the other requester may still be granted.
REQ-029 RID values outside 0..1 (tagbits>1): RREADY=1, data discarded, counters unchanged.

Reset
REQ-030 While ARESETn=0: state=IDLE, ARVALID=0, AR payload=0, last_grant=1 (requester 0 wins first tie), outst0=outst1=0.
REQ-031 Reset asserted mid-ISSUE drops ARVALID immediately; the pending request is lost and is not re-presented.
REQ-032 Counters restart at 0 after reset regardless of in-flight bursts.

Verification
REQ-033 req0 and req1 valid together from reset, ARREADY=1 -> AR issues ID 0, then ID 1, then ID 0, alternating every 2 cycles.
REQ-034 req0 addr=0x100, len=3, ARREADY held low 5 cycles -> ARVALID=1 and ARADDR=0x100 stable for all 5 cycles; handshake on the 6th; outst0=1.
REQ-035 req0 only, MaxOutst=2, no R traffic -> two bursts issued, then req0_ready stays 0; a single R beat with RID=0, RLAST=1 -> outst0=1 and req0 is granted again.
REQ-036 RVALID=1, RID=1, rsp1_ready=0 -> RREADY=0, rsp1_valid=1, rsp0_valid=0; rsp1_ready=1 with RLAST=1 -> outst1 decremented.
REQ-037 AR handshake (ARID=0) on the same edge as an RLAST handshake (RID=0) with outst0=1 -> outst0 stays 1.
REQ-038 ARESETn pulsed low during ISSUE -> ARVALID=0 within the same cycle, outst0=outst1=0, first grant after release goes to requester 0.
